mmu_dma: RTL and testbench

//  Next-generation Game Boy memory management unit with a built-in OAM DMA engine.

---
 rtl/mmu_pkg.sv | 42 ++++
 rtl/mmu_dma_engine.sv | 101 ++++++++++
 rtl/mmu_dma.sv | 203 ++++++++++++++++++++
 tb/tb_mmu_dma.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU / OAM DMA slice: address map, DMA state
// encoding and small address/data helpers.
package mmu_pkg;

  localparam logic [15:0] MAIN_LIMIT   = 16'hFDFF;
  localparam logic [15:0] VRAM_BASE    = 16'h8000;
  localparam logic [15:0] VRAM_LIMIT   = 16'h9FFF;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] OAM_LIMIT    = 16'hFE9F;
  localparam logic [15:0] IO_BASE      = 16'hFF00;
  localparam logic [15:0] PERIPH_LIMIT = 16'hFF3F;
  localparam logic [15:0] JOYPAD_ADDR  = 16'hFF00;
  localparam logic [15:0] TIMER_BASE   = 16'hFF04;
  localparam logic [15:0] TIMER_LIMIT  = 16'hFF07;
  localparam logic [15:0] IF_ADDR      = 16'hFF0F;
  localparam logic [15:0] SOUND_BASE   = 16'hFF10;
  localparam logic [15:0] SOUND_LIMIT  = 16'hFF3F;
  localparam logic [15:0] PPU_REG_BASE = 16'hFF40;
  localparam logic [15:0] PPU_REG_LIMIT= 16'hFF4B;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] BOOT_OFF_ADDR= 16'hFF50;
  localparam logic [15:0] HRAM_BASE    = 16'hFF80;
  localparam logic [15:0] IE_ADDR      = 16'hFFFF;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_READ,
    DMA_WRITE
  } dma_state_t;

  // Source pages E0h-FFh alias work RAM (echo region).
  function automatic logic [7:0] dma_src_fold(input logic [7:0] src);
    return (src >= 8'hE0) ? (src & 8'hDF) : src;
  endfunction

  // Synthesizable stand-in boot image; swap for the production ROM table.
  function automatic logic [7:0] boot_rom_byte(input logic [7:0] addr);
    return (addr * 8'd7) + 8'h31;
  endfunction

endpackage

// File: rtl/mmu_dma_engine.sv
// OAM DMA engine: FF46h shadow/source register, transfer FSM, byte index,
// fetched-byte latch and the dma_active flag.
module mmu_dma_engine
  import mmu_pkg::*;
#(
  parameter int unsigned DMA_LEN   = 160,
  parameter int unsigned DMA_DELAY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  start_src,
  input  logic [7:0]  rd_data,
  output logic [7:0]  shadow,
  output logic [15:0] src_addr,
  output logic [15:0] oam_addr,
  output logic [7:0]  wr_data,
  output logic        dma_read,
  output logic        dma_write,
  output logic        dma_active
);

  localparam int unsigned      IDX_W    = $clog2(DMA_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DMA_LEN - 1);
  localparam logic [1:0]       DLY_LAST = (DMA_DELAY > 0) ? 2'(DMA_DELAY - 1) : 2'd0;
  localparam dma_state_t       KICK_STATE = (DMA_DELAY == 0) ? DMA_READ : DMA_START;

  dma_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       dly_q, dly_d;
  logic [7:0]       src_q, src_d;
  logic [7:0]       latch_q;
  logic [15:0]      idx_ext;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= DMA_IDLE;
    else          state_q <= state_d;
  end

  // Index, delay counter and source register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      dly_q <= '0;
      src_q <= '0;
    end else begin
      idx_q <= idx_d;
      dly_q <= dly_d;
      src_q <= src_d;
    end
  end

  // Byte fetched during READ, written to OAM in the following WRITE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                  latch_q <= '0;
    else if (state_q == DMA_READ)  latch_q <= rd_data;
  end

  // Next-state logic; an FF46h write overrides the sequence from any state,
  // discarding whatever byte was in flight.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    src_d   = src_q;
    case (state_q)
      DMA_IDLE: ;
      DMA_START: begin
        if (dly_q == DLY_LAST) state_d = DMA_READ;
        else                   dly_d   = dly_q + 2'd1;
      end
      DMA_READ:  state_d = DMA_WRITE;
      DMA_WRITE: begin
        if (idx_q == IDX_LAST) begin
          state_d = DMA_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = DMA_READ;
        end
      end
      default:   state_d = DMA_IDLE;
    endcase
    if (start) begin
      src_d   = start_src;
      idx_d   = '0;
      dly_d   = '0;
      state_d = KICK_STATE;
    end
  end

  assign idx_ext    = 16'(idx_q);
  assign shadow     = src_q;
  assign src_addr   = {dma_src_fold(src_q), idx_ext[7:0]};
  assign oam_addr   = OAM_BASE + idx_ext;
  assign wr_data    = latch_q;
  assign dma_read   = (state_q == DMA_READ);
  assign dma_write  = (state_q == DMA_WRITE);
  assign dma_active = (state_q != DMA_IDLE);

endmodule

// File: rtl/mmu_dma.sv
// Game Boy MMU with integrated OAM DMA: CPU address decode, main/PPU bus
// muxing and arbitration, HRAM, peripheral selects.
// Optional boot ROM overlay at 0000-00FFh when MMU_BOOT_ROM_EN is defined.
module mmu_dma
  import mmu_pkg::*;
#(
  parameter int unsigned DMA_LEN    = 160,
  parameter int unsigned DMA_DELAY  = 1,
  parameter int unsigned HRAM_DEPTH = 127
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Di_cpu,
  output logic [7:0]  Do_cpu,
  input  logic        rd_cpu_n,
  input  logic        wr_cpu_n,
  output logic [15:0] A,
  output logic [7:0]  Do,
  input  logic [7:0]  Di,
  output logic        rd_n,
  output logic        wr_n,
  output logic        cs_n,
  output logic [15:0] A_ppu,
  output logic [7:0]  Do_ppu,
  input  logic [7:0]  Di_ppu,
  output logic        rd_ppu_n,
  output logic        wr_ppu_n,
  output logic        cs_ppu,
  input  logic [7:0]  Do_interrupt,
  input  logic [7:0]  Do_timer,
  input  logic [7:0]  Do_sound,
  input  logic [7:0]  Do_joypad,
  output logic        cs_interrupt,
  output logic        cs_timer,
  output logic        cs_sound,
  output logic        cs_joypad,
  output logic        dma_active
);

  localparam logic [15:0] HRAM_LAST = HRAM_BASE + 16'(HRAM_DEPTH) - 16'd1;

  logic main_hit, ppu_hit, dma_reg_hit, hram_hit;
  logic int_hit, timer_hit, sound_hit, joy_hit, periph_hit;
  logic cpu_ok, cpu_wr, dma_start, main_sel;
  logic boot_hit, dma_src_boot, src_vram;
  logic [7:0]  boot_data, dma_boot_data, dma_rd_data, hram_rdata, shadow, dma_wr_data;
  logic [15:0] src_addr, oam_addr;
  logic        dma_read, dma_write;
  logic [6:0]  hram_idx;
  logic [7:0]  hram [HRAM_DEPTH];

  // CPU address decode.
  always_comb begin
    main_hit    = (A_cpu <= MAIN_LIMIT);
    ppu_hit     = ((A_cpu >= VRAM_BASE) && (A_cpu <= VRAM_LIMIT)) ||
                  ((A_cpu >= OAM_BASE) && (A_cpu <= OAM_LIMIT)) ||
                  ((A_cpu >= PPU_REG_BASE) && (A_cpu <= PPU_REG_LIMIT) &&
                   (A_cpu != DMA_REG_ADDR));
    dma_reg_hit = (A_cpu == DMA_REG_ADDR);
    hram_hit    = (A_cpu >= HRAM_BASE) && (A_cpu <= HRAM_LAST);
    int_hit     = (A_cpu == IF_ADDR) || (A_cpu == IE_ADDR);
    timer_hit   = (A_cpu >= TIMER_BASE) && (A_cpu <= TIMER_LIMIT);
    sound_hit   = (A_cpu >= SOUND_BASE) && (A_cpu <= SOUND_LIMIT);
    joy_hit     = (A_cpu == JOYPAD_ADDR);
    periph_hit  = ((A_cpu >= IO_BASE) && (A_cpu <= PERIPH_LIMIT)) || (A_cpu == IE_ADDR);
    // While DMA owns the buses only HRAM, peripherals and FF46h stay reachable.
    cpu_ok      = !dma_active || hram_hit || periph_hit || dma_reg_hit;
  end

  assign cpu_wr    = reset_n && !wr_cpu_n;
  assign dma_start = cpu_wr && dma_reg_hit;
  assign hram_idx  = A_cpu[6:0];
  assign hram_rdata = hram[hram_idx];
  assign src_vram  = (src_addr >= VRAM_BASE) && (src_addr <= VRAM_LIMIT);

`ifdef MMU_BOOT_ROM_EN
  logic boot_en_q;
  logic boot_off_wr;

  assign boot_off_wr = cpu_wr && !dma_active && (A_cpu == BOOT_OFF_ADDR) && (Di_cpu == 8'h01);

  // Overlay enable: set only by reset, cleared by writing 01h to FF50h.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         boot_en_q <= 1'b1;
    else if (boot_off_wr) boot_en_q <= 1'b0;
  end

  assign boot_hit      = boot_en_q && (A_cpu[15:8] == 8'h00);
  assign dma_src_boot  = boot_en_q && (src_addr[15:8] == 8'h00);
  assign boot_data     = boot_rom_byte(A_cpu[7:0]);
  assign dma_boot_data = boot_rom_byte(src_addr[7:0]);
`else
  assign boot_hit      = 1'b0;
  assign dma_src_boot  = 1'b0;
  assign boot_data     = 8'hFF;
  assign dma_boot_data = 8'hFF;
`endif

  // Boot overlay only steals reads; writes to 0000-00FFh still reach the cartridge.
  assign main_sel = main_hit && !(boot_hit && !rd_cpu_n);

  assign dma_rd_data = src_vram ? Di_ppu : (dma_src_boot ? dma_boot_data : Di);

  mmu_dma_engine #(
    .DMA_LEN   (DMA_LEN),
    .DMA_DELAY (DMA_DELAY)
  ) u_engine (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (dma_start),
    .start_src  (Di_cpu),
    .rd_data    (dma_rd_data),
    .shadow     (shadow),
    .src_addr   (src_addr),
    .oam_addr   (oam_addr),
    .wr_data    (dma_wr_data),
    .dma_read   (dma_read),
    .dma_write  (dma_write),
    .dma_active (dma_active)
  );

  // HRAM: synchronous write, combinational read.
  always_ff @(posedge clock) begin
    if (cpu_wr && hram_hit) hram[hram_idx] <= Di_cpu;
  end

  // CPU read data mux.
  always_comb begin
    Do_cpu = 8'hFF;
    if (cpu_ok) begin
      if (dma_reg_hit)    Do_cpu = shadow;
      else if (hram_hit)  Do_cpu = hram_rdata;
      else if (int_hit)   Do_cpu = Do_interrupt;
      else if (timer_hit) Do_cpu = Do_timer;
      else if (sound_hit) Do_cpu = Do_sound;
      else if (joy_hit)   Do_cpu = Do_joypad;
      else if (boot_hit)  Do_cpu = boot_data;
      else if (ppu_hit)   Do_cpu = Di_ppu;
      else if (main_hit)  Do_cpu = Di;
    end
  end

  // Main/PPU bus drive: CPU passthrough when idle, DMA strobes win when active.
  always_comb begin
    A        = A_cpu;
    Do       = Di_cpu;
    A_ppu    = A_cpu;
    Do_ppu   = Di_cpu;
    cs_n     = 1'b1;
    rd_n     = 1'b1;
    wr_n     = 1'b1;
    cs_ppu   = 1'b0;
    rd_ppu_n = 1'b1;
    wr_ppu_n = 1'b1;
    if (!dma_active) begin
      if (main_sel) begin
        cs_n = 1'b0;
        rd_n = rd_cpu_n;
        wr_n = wr_cpu_n;
      end
      if (ppu_hit) begin
        cs_ppu   = 1'b1;
        rd_ppu_n = rd_cpu_n;
        wr_ppu_n = wr_cpu_n;
      end
    end
    if (dma_read) begin
      if (src_vram) begin
        A_ppu    = src_addr;
        cs_ppu   = 1'b1;
        rd_ppu_n = 1'b0;
      end else if (!dma_src_boot) begin
        A    = src_addr;
        cs_n = 1'b0;
        rd_n = 1'b0;
      end
    end
    if (dma_write) begin
      A_ppu    = oam_addr;
      Do_ppu   = dma_wr_data;
      cs_ppu   = 1'b1;
      wr_ppu_n = 1'b0;
    end
    if (!reset_n) begin
      cs_n     = 1'b1;
      rd_n     = 1'b1;
      wr_n     = 1'b1;
      cs_ppu   = 1'b0;
      rd_ppu_n = 1'b1;
      wr_ppu_n = 1'b1;
    end
  end

  // Peripheral chip selects follow the CPU address regardless of DMA.
  always_comb begin
    cs_interrupt = reset_n && int_hit;
    cs_timer     = reset_n && timer_hit;
    cs_sound     = reset_n && sound_hit;
    cs_joypad    = reset_n && joy_hit;
  end

endmodule

// File: tb/tb_mmu_dma.sv
// Directed bench for mmu_dma: decode vector table plus DMA sequences.
module tb_mmu_dma;

  logic        clock, reset_n;
  logic [15:0] A_cpu;
  logic [7:0]  Di_cpu, Do_cpu;
  logic        rd_cpu_n, wr_cpu_n;
  logic [15:0] A;
  logic [7:0]  Do, Di;
  logic        rd_n, wr_n, cs_n;
  logic [15:0] A_ppu;
  logic [7:0]  Do_ppu, Di_ppu;
  logic        rd_ppu_n, wr_ppu_n, cs_ppu;
  logic [7:0]  Do_interrupt, Do_timer, Do_sound, Do_joypad;
  logic        cs_interrupt, cs_timer, cs_sound, cs_joypad, dma_active;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem_main [65536];
  logic [7:0] mem_ppu  [65536];

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ppat(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'hC3;
  endfunction

  mmu_dma #(.DMA_LEN(160), .DMA_DELAY(1), .HRAM_DEPTH(127)) dut (
    .clock(clock), .reset_n(reset_n),
    .A_cpu(A_cpu), .Di_cpu(Di_cpu), .Do_cpu(Do_cpu),
    .rd_cpu_n(rd_cpu_n), .wr_cpu_n(wr_cpu_n),
    .A(A), .Do(Do), .Di(Di), .rd_n(rd_n), .wr_n(wr_n), .cs_n(cs_n),
    .A_ppu(A_ppu), .Do_ppu(Do_ppu), .Di_ppu(Di_ppu),
    .rd_ppu_n(rd_ppu_n), .wr_ppu_n(wr_ppu_n), .cs_ppu(cs_ppu),
    .Do_interrupt(Do_interrupt), .Do_timer(Do_timer),
    .Do_sound(Do_sound), .Do_joypad(Do_joypad),
    .cs_interrupt(cs_interrupt), .cs_timer(cs_timer),
    .cs_sound(cs_sound), .cs_joypad(cs_joypad),
    .dma_active(dma_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign Do_interrupt = 8'h1E;
  assign Do_timer     = 8'h2D;
  assign Do_sound     = 8'h3C;
  assign Do_joypad    = 8'h4B;
  assign Di           = mem_main[A];
  assign Di_ppu       = mem_ppu[A_ppu];

  // Main-bus and PPU-bus memory models.
  initial begin : bus_model
    for (int i = 0; i < 65536; i++) begin
      mem_main[i] = pat(16'(i));
      mem_ppu[i]  = ppat(16'(i));
    end
    forever begin
      @(posedge clock);
      if (!cs_n && !wr_n)        mem_main[A]    = Do;
      if (cs_ppu && !wr_ppu_n)   mem_ppu[A_ppu] = Do_ppu;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    A_cpu = a; Di_cpu = d; rd_cpu_n = 1'b1; wr_cpu_n = 1'b0;
    @(posedge clock); #1;
    wr_cpu_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    A_cpu = a; rd_cpu_n = 1'b0; wr_cpu_n = 1'b1;
    @(negedge clock);
    d = Do_cpu;
    @(posedge clock); #1;
    rd_cpu_n = 1'b1;
  endtask

  // Counts active cycles (bounded) and returns just after a rising edge.
  task automatic run_until_idle(output int cyc);
    cyc = 0;
    while (cyc < 1000) begin
      @(negedge clock);
      if (!dma_active) break;
      cyc++;
    end
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  exp_do;
    logic        exp_cs_n;
    logic        exp_cs_ppu;
    logic [3:0]  exp_per;   // {interrupt, timer, sound, joypad}
  } vec_t;

  vec_t       vecs [23];
  logic [7:0] v;
  int         cyc;

  initial begin
    reset_n = 1'b0; A_cpu = 16'hC000; Di_cpu = 8'h00; rd_cpu_n = 1'b0; wr_cpu_n = 1'b1;
    #2;
    check("reset_dma_active", dma_active, 0);
    check("reset_strobes", {rd_n, wr_n, rd_ppu_n, wr_ppu_n, cs_n, cs_ppu}, 6'b111110);
    #20 reset_n = 1'b1;
    rd_cpu_n = 1'b1;
    @(posedge clock); #1;

    cpu_write(16'hC000, 8'h11);
    cpu_write(16'hFF80, 8'hA1);
    cpu_write(16'hFFFE, 8'hB2);

    vecs[0]  = '{16'hC000, 8'h11,             1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{16'hFDFF, pat(16'hFDFF),     1'b0, 1'b0, 4'b0000};
    vecs[2]  = '{16'h8000, ppat(16'h8000),    1'b0, 1'b1, 4'b0000};
    vecs[3]  = '{16'h9FFF, ppat(16'h9FFF),    1'b0, 1'b1, 4'b0000};
    vecs[4]  = '{16'hA000, pat(16'hA000),     1'b0, 1'b0, 4'b0000};
    vecs[5]  = '{16'hFE00, ppat(16'hFE00),    1'b1, 1'b1, 4'b0000};
    vecs[6]  = '{16'hFE9F, ppat(16'hFE9F),    1'b1, 1'b1, 4'b0000};
    vecs[7]  = '{16'hFEA0, 8'hFF,             1'b1, 1'b0, 4'b0000};
    vecs[8]  = '{16'hFF40, ppat(16'hFF40),    1'b1, 1'b1, 4'b0000};
    vecs[9]  = '{16'hFF4B, ppat(16'hFF4B),    1'b1, 1'b1, 4'b0000};
    vecs[10] = '{16'hFF46, 8'h00,             1'b1, 1'b0, 4'b0000};
    vecs[11] = '{16'hFF4C, 8'hFF,             1'b1, 1'b0, 4'b0000};
    vecs[12] = '{16'hFF00, 8'h4B,             1'b1, 1'b0, 4'b0001};
    vecs[13] = '{16'hFF04, 8'h2D,             1'b1, 1'b0, 4'b0100};
    vecs[14] = '{16'hFF07, 8'h2D,             1'b1, 1'b0, 4'b0100};
    vecs[15] = '{16'hFF08, 8'hFF,             1'b1, 1'b0, 4'b0000};
    vecs[16] = '{16'hFF0F, 8'h1E,             1'b1, 1'b0, 4'b1000};
    vecs[17] = '{16'hFF10, 8'h3C,             1'b1, 1'b0, 4'b0010};
    vecs[18] = '{16'hFF3F, 8'h3C,             1'b1, 1'b0, 4'b0010};
    vecs[19] = '{16'hFF80, 8'hA1,             1'b1, 1'b0, 4'b0000};
    vecs[20] = '{16'hFFFE, 8'hB2,             1'b1, 1'b0, 4'b0000};
    vecs[21] = '{16'hFF7F, 8'hFF,             1'b1, 1'b0, 4'b0000};
    vecs[22] = '{16'hFFFF, 8'h1E,             1'b1, 1'b0, 4'b1000};

    for (int i = 0; i < 23; i++) begin
      A_cpu = vecs[i].addr; rd_cpu_n = 1'b0; wr_cpu_n = 1'b1;
      @(negedge clock);
      check($sformatf("vec%0d_%h", i, vecs[i].addr),
            {Do_cpu, cs_n, cs_ppu, cs_interrupt, cs_timer, cs_sound, cs_joypad},
            {vecs[i].exp_do, vecs[i].exp_cs_n, vecs[i].exp_cs_ppu, vecs[i].exp_per});
      @(posedge clock); #1;
    end
    rd_cpu_n = 1'b1;

    // Basic transfer from work RAM.
    cpu_write(16'hFF46, 8'hC0);
    run_until_idle(cyc);
    check("t1_active_cycles", cyc, 321);
    check("t1_oam_first", mem_ppu[16'hFE00], 8'h11);
    check("t1_oam_last", mem_ppu[16'hFE9F], pat(16'hC09F));

    // Transfer sourced from VRAM over the PPU bus.
    cpu_write(16'hFF46, 8'h80);
    run_until_idle(cyc);
    check("t1b_active_cycles", cyc, 321);
    check("t1b_oam_first", mem_ppu[16'hFE00], ppat(16'h8000));
    check("t1b_oam_last", mem_ppu[16'hFE9F], ppat(16'h809F));

    // CPU lockout while DMA runs.
    cpu_write(16'hFF46, 8'hC0);
    cpu_read(16'hC000, v);
    check("t2_locked_read", v, 8'hFF);
    cpu_write(16'hFF85, 8'h3C);
    cpu_read(16'hFF85, v);
    check("t2_hram_rt", v, 8'h3C);
    cpu_read(16'hFF04, v);
    check("t2_timer_read", v, 8'h2D);
    A_cpu = 16'h8000; Di_cpu = 8'hEE; wr_cpu_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("t2_wr_block%0d", k),
            {wr_n, wr_ppu_n | (A_ppu[15:8] == 8'hFE)}, 2'b11);
      @(posedge clock); #1;
    end
    wr_cpu_n = 1'b1;
    run_until_idle(cyc);
    check("t2_done", dma_active, 0);
    check("t2_vram_untouched", mem_ppu[16'h8000], ppat(16'h8000));

    // Restart mid-transfer with a new source.
    cpu_write(16'hFF46, 8'hC0);
    repeat (101) @(posedge clock);
    #1;
    check("t3_oam_idx49", mem_ppu[16'hFE31], pat(16'hC031));
    cpu_write(16'hFF46, 8'hD0);
    run_until_idle(cyc);
    check("t3_restart_cycles", cyc, 321);
    check("t3_oam_first", mem_ppu[16'hFE00], pat(16'hD000));
    check("t3_oam_last", mem_ppu[16'hFE9F], pat(16'hD09F));
    cpu_read(16'hFF46, v);
    check("t3_shadow", v, 8'hD0);

    // Echo fold of source page FEh onto DEh.
    cpu_write(16'hFF46, 8'hFE);
    run_until_idle(cyc);
    check("t4_active_cycles", cyc, 321);
    check("t4_oam_first", mem_ppu[16'hFE00], pat(16'hDE00));
    check("t4_oam_last", mem_ppu[16'hFE9F], pat(16'hDE9F));

    // Reset in the middle of a transfer.
    cpu_write(16'hFF46, 8'hC0);
    repeat (21) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("t5_active_async", dma_active, 0);
    check("t5_strobes", {rd_n, wr_n, rd_ppu_n, wr_ppu_n, cs_n, cs_ppu}, 6'b111110);
    check("t5_oam_kept", mem_ppu[16'hFE09], pat(16'hC009));
    check("t5_oam_unwritten", mem_ppu[16'hFE0A], pat(16'hDE0A));
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    check("t5_idle_after", dma_active, 0);
    cpu_read(16'hFF46, v);
    check("t5_shadow_cleared", v, 8'h00);

    // Boot ROM overlay.
`ifdef MMU_BOOT_ROM_EN
    cpu_read(16'h0000, v);
    check("t6_boot0", v, 8'h31);
    cpu_read(16'h0001, v);
    check("t6_boot1", v, 8'h38);
    cpu_write(16'hFF50, 8'h02);
    cpu_read(16'h0000, v);
    check("t6_boot_kept", v, 8'h31);
    cpu_write(16'hFF50, 8'h01);
    cpu_read(16'h0000, v);
    check("t6_cart0", v, pat(16'h0000));
`else
    cpu_read(16'h0000, v);
    check("t6_cart0", v, pat(16'h0000));
    cpu_write(16'hFF50, 8'h01);
    cpu_read(16'h0000, v);
    check("t6_cart0_after", v, pat(16'h0000));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
